// File: rtl/mips_mc_pkg.sv
// Shared encodings, FSM states and instruction decode for the multi-cycle MIPS core.
package mips_mc_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   localparam logic [RW-1:0] RA = 5'd31;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   typedef enum logic [3:0] {
      I_NONE, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
   } instr_t;

   // Anything not listed (including the all-zero nop) decodes to I_NONE.
   function automatic instr_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
      instr_t r;
      r = I_NONE;
      case (op)
         OP_R: begin
            case (funct)
               FN_ADDU: r = I_ADDU;
               FN_SUBU: r = I_SUBU;
               FN_JR:   r = I_JR;
               default: r = I_NONE;
            endcase
         end
         OP_ORI:  r = I_ORI;
         OP_LUI:  r = I_LUI;
         OP_LW:   r = I_LW;
         OP_SW:   r = I_SW;
         OP_BEQ:  r = I_BEQ;
         OP_J:    r = I_J;
         OP_JAL:  r = I_JAL;
         default: r = I_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 reads as zero.
module mc_regfile
   import mips_mc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [RW-1:0]   ra1,
   input  logic [RW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [RW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);

   localparam int NREG = 32;

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_mc.sv
// Multi-cycle MIPS core (FETCH/DECODE/EXEC/MEM/WB) with req/ready instruction and data ports.
module mips_mc
   import mips_mc_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned IM_AW    = 10,
   parameter int unsigned DM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   output logic             i_req,
   output logic [IM_AW-1:0] i_addr,
   input  logic [31:0]      i_rdata,
   input  logic             i_ready,
   output logic             d_req,
   output logic             d_we,
   output logic [DM_AW-1:0] d_addr,
   output logic [31:0]      d_wdata,
   input  logic [31:0]      d_rdata,
   input  logic             d_ready,
   output logic [31:0]      pc_o,
   output logic             wb_en,
   output logic [4:0]       wb_reg,
   output logic [31:0]      wb_data
);

   state_t           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [DM_AW-1:0] daddr_q, daddr_d;
   logic [XLEN-1:0]  dwdata_q, dwdata_d, wbdata_q, wbdata_d;
   logic [RW-1:0]    wbreg_q, wbreg_d;
   logic             dwe_q, dwe_d;

   logic [5:0]       op, funct;
   logic [RW-1:0]    rs, rt, rd;
   logic [15:0]      imm;
   instr_t           ins;
   logic [XLEN-1:0]  pc4, bpc, jtarget, sext, alu_c, rs_val, rt_val;
   logic             wb_fire;

   assign op      = ir_q[31:26];
   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign imm     = ir_q[15:0];
   assign funct   = ir_q[5:0];
   assign ins     = decode_instr(op, funct);
   assign sext    = {{16{imm[15]}}, imm};
   assign pc4     = pc_q + 32'd4;
   assign bpc     = pc4 + {sext[29:0], 2'b00};
   assign jtarget = {pc4[31:28], ir_q[25:0], 2'b00};
   assign wb_fire = (state_q == S_WB) && (wbreg_q != '0);

   mc_regfile u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rs_val),
      .rd2   (rt_val),
      .we    (wb_fire),
      .wa    (wbreg_q),
      .wd    (wbdata_q)
   );

   // ALU works on the operands latched in DECODE
   always_comb begin
      alu_c = '0;
      case (ins)
         I_ADDU:     alu_c = a_q + b_q;
         I_SUBU:     alu_c = a_q - b_q;
         I_ORI:      alu_c = a_q | {16'h0, imm};
         I_LUI:      alu_c = {imm, 16'h0};
         I_LW, I_SW: alu_c = a_q + sext;
         default:    alu_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= PC_RESET;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         daddr_q  <= '0;
         dwdata_q <= '0;
         dwe_q    <= 1'b0;
         wbreg_q  <= '0;
         wbdata_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         dwe_q    <= dwe_d;
         wbreg_q  <= wbreg_d;
         wbdata_q <= wbdata_d;
      end
   end

   // Next state; PC only moves on the edge that re-enters FETCH
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      dwe_d    = dwe_q;
      wbreg_d  = wbreg_q;
      wbdata_d = wbdata_q;
      case (state_q)
         S_FETCH: begin
            if (i_ready) begin
               ir_d    = i_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = rs_val;
            b_d = rt_val;
            case (ins)
               I_JAL: begin
                  state_d  = S_WB;
                  wbreg_d  = RA;
                  wbdata_d = pc4;
               end
               I_J: begin
                  state_d = S_FETCH;
                  pc_d    = jtarget;
               end
               I_JR: begin
                  state_d = S_FETCH;
                  pc_d    = rs_val;
               end
               I_NONE: begin
                  state_d = S_FETCH;
                  pc_d    = pc4;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (ins)
               I_BEQ: begin
                  state_d = S_FETCH;
                  pc_d    = (a_q == b_q) ? bpc : pc4;
               end
               I_LW, I_SW: begin
                  state_d  = S_MEM;
                  daddr_d  = alu_c[DM_AW+1:2];
                  dwdata_d = b_q;
                  dwe_d    = (ins == I_SW);
               end
               default: begin
                  state_d  = S_WB;
                  wbreg_d  = ((ins == I_ADDU) || (ins == I_SUBU)) ? rd : rt;
                  wbdata_d = alu_c;
               end
            endcase
         end
         S_MEM: begin
            if (d_ready) begin
               if (ins == I_LW) begin
                  state_d  = S_WB;
                  wbreg_d  = rt;
                  wbdata_d = d_rdata;
               end else begin
                  state_d = S_FETCH;
                  pc_d    = pc4;
               end
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            pc_d    = (ins == I_JAL) ? jtarget : pc4;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Outputs come from registers only; reset forces the idle values
   always_comb begin
      i_req   = 1'b0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      i_addr  = PC_RESET[IM_AW+1:2];
      d_addr  = '0;
      d_wdata = '0;
      pc_o    = PC_RESET;
      wb_en   = 1'b0;
      wb_reg  = '0;
      wb_data = '0;
      if (!reset) begin
         i_req   = (state_q == S_FETCH);
         d_req   = (state_q == S_MEM);
         d_we    = (state_q == S_MEM) && dwe_q;
         i_addr  = pc_q[IM_AW+1:2];
         d_addr  = daddr_q;
         d_wdata = dwdata_q;
         pc_o    = pc_q;
         wb_en   = wb_fire;
         wb_reg  = wbreg_q;
         wb_data = wbdata_q;
      end
   end

endmodule

// File: doc/mips_mc.md
# mips_mc

Multi-cycle MIPS core with variable-latency instruction and data memory handshakes, parametrised in reset PC and memory address width. It executes `nop`, `addu`, `subu`, `ori`, `lui`, `lw`, `sw`, `beq`, `j`, `jal` and `jr` through a five-state controller. It sits at the top of the processor in place of the single-cycle datapath, with instruction and data memories external behind req/ready ports. Register-write trace outputs drive the testbench checker.

## Interface
- `PC_RESET`, default 32'h0000_3000: PC value after reset.
- `IM_AW`, default 10: instruction word-address width; `i_addr` = PC[IM_AW+1:2].
- `DM_AW`, default 10: data word-address width; `d_addr` = ALU result [DM_AW+1:2].

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` out 1: instruction fetch request.
- `i_addr` out IM_AW: instruction word address.
- `i_rdata` in 32: fetched instruction.
- `i_ready` in 1: fetch completes on an edge where `i_req && i_ready`.
- `d_req` out 1: data access request.
- `d_we` out 1: 1 = store, 0 = load.
- `d_addr` out DM_AW: data word address.
- `d_wdata` out 32: store data (rt).
- `d_rdata` in 32: load data, sampled when `d_req && d_ready`.
- `d_ready` in 1: access completes on an edge where `d_req && d_ready`.
- `pc_o` out 32: PC of the instruction in flight.
- `wb_en` out 1: one-cycle pulse per committed register write.
- `wb_reg` out 5: destination register, valid with `wb_en`.
- `wb_data` out 32: written value, valid with `wb_en`.

## Operation
- States are FETCH, DECODE, EXEC, MEM and WB.
- FETCH:
  - `i_req` = 1.
  - Holds until `i_ready`, then latches IR and goes to DECODE.
- DECODE:
  - Latches A = GPR[rs] and B = GPR[rt].
  - Computes PC4 = PC+4 and BPC = PC4 + (sext(imm16) << 2).
- Per-instruction paths, where PC update happens at the exit of the last state:
  - `nop` (all-zero word) and any unsupported opcode/funct: F→D, PC = PC4.
  - `j`: F→D, PC = {PC4[31:28], imm26, 2'b00}.
  - `jr`: F→D, PC = GPR[rs].
  - `jal`: F→D→WB. Writes $31 = PC4; PC = jump target.
  - `beq`: F→D→EXEC. PC = (A == B) ? BPC : PC4.
  - `addu`/`subu`: F→D→E→WB. rd = A ± B.
  - `ori`: F→D→E→WB. rt = A | zext(imm16).
  - `lui`: F→D→E→WB. rt = {imm16, 16'h0}.
  - `lw`: F→D→E→MEM→WB. Address = A + sext(imm16); rt = `d_rdata`.
  - `sw`: F→D→E→MEM. Same address rule; `d_we` = 1, `d_wdata` = B.
- MEM: `d_req` held high with stable `d_addr`, `d_we` and `d_wdata` until `d_ready`.
- Arithmetic:
  - All arithmetic is mod 2^32 with no overflow trap.
  - Address bits [1:0] are ignored.
  - Addresses wider than DM_AW alias.
- Register file:
  - $0 always reads 0.
  - A write to $0 is discarded and `wb_en` stays 0.
- Reset:
  - Takes effect in any state, including mid-handshake.
  - State → FETCH, PC → PC_RESET, all GPRs → 0, IR → 0.
  - A pending memory transfer is abandoned; a `d_ready` in the reset cycle has no effect.

## Timing
- Output values while reset is high: `i_req` = 0, `d_req` = 0, `d_we` = 0, `wb_en` = 0, `pc_o` = PC_RESET, `i_addr` = PC_RESET[IM_AW+1:2], `d_addr` = 0, `d_wdata` = 0, `wb_reg` = 0, `wb_data` = 0.
- First fetch: `i_req` rises in the first cycle with `reset` low.
- `i_req` and `d_req` are decoded from state and registered address/data. There is no combinational path from `i_ready`/`d_ready` to any output.
- Zero-wait memory (ready tied 1) gives these cycles per instruction:
  - `j`, `jr`, `nop`: 2.
  - `jal`, `beq`: 3.
  - `addu`, `subu`, `ori`, `lui`, `sw`: 4.
  - `lw`: 5.
- Each cycle of ready low adds one cycle in FETCH or MEM.
- `wb_en` is high exactly during the WB cycle. The GPR write occurs at the end of that cycle and is visible to the next DECODE.
- `pc_o` changes only on the FETCH entry edge.

## Structure
- Package `mips_mc_pkg` holds:
  - Opcodes: R 000000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Functs: addu 100001, subu 100011, jr 001000.
  - The state enum and the `RA` = 5'd31 constant.
- Sub-module `mc_regfile`:
  - 32×32, two asynchronous read ports and one synchronous write port with write enable.
  - $0 hardwired to 0; synchronous reset clears all registers.
- Decode, ALU, sign/zero extend and the FSM stay in `mips_mc`.

## Test plan
- Reset, then `ori $1,$0,0x1234`; `lui $2,0xABCD`; `addu $3,$1,$2` with ready tied 1 → trace shows $1 = 0x00001234, $2 = 0xABCD0000, $3 = 0xABCD1234; `pc_o` sequence 0x3000, 0x3004, 0x3008.
- `sw $3,8($0)` then `lw $4,8($0)` against a bench memory with `d_ready` delayed 3 cycles → `d_addr` = 2 held stable through the wait, store data 0xABCD1234, $4 = 0xABCD1234, `lw` takes 8 cycles.
- `beq $1,$1,-1` at 0x3010 → next `pc_o` = 0x3010 (loop). `beq $1,$2,+2` with unequal registers → next `pc_o` = 0x3014.
- `jal 0x3100` at 0x300C → $31 = 0x3010, next `pc_o` = 0x3100. `jr $31` → next `pc_o` = 0x3010.
- `ori $0,$0,5` then `addu $5,$0,$0` → no `wb_en` for $0; $5 = 0. An unsupported opcode advances PC by 4 with no write.
- Assert `reset` during MEM with `d_req` high and `d_ready` low → next cycle `d_req` = 0, `pc_o` = 0x3000, GPRs = 0, then fetch restarts.
